// File: rtl/cnn_stream_pkg.sv
// Types and helpers shared by the CNN streaming stages (conv wrapper, max-pool).
package cnn_stream_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } stream_state_t;

  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Single-port partial-max line buffer: asynchronous read, synchronous write
// on the same address in one cycle. Contents are not reset.
module pool_line_buf
  import cnn_stream_pkg::*;
#(
  parameter int unsigned DEPTH  = 448,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/maxpool2d_stream.sv
// Streaming 2x2 stride-2 max-pool over a raster (row, col, channel-innermost)
// feature map, using a half-row partial-max buffer instead of frame storage.
module maxpool2d_stream
  import cnn_stream_pkg::*;
#(
  parameter int unsigned H_IN   = 32,
  parameter int unsigned W_IN   = 32,
  parameter int unsigned CH     = 28,
  parameter int unsigned DATA_W = cnn_stream_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned RW    = (H_IN > 1) ? $clog2(H_IN) : 1;
  localparam int unsigned CW    = (W_IN > 1) ? $clog2(W_IN) : 1;
  localparam int unsigned KW    = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned DEPTH = (W_IN / 2) * CH;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [RW-1:0] R_LAST = RW'(H_IN - 1);
  localparam logic [CW-1:0] C_LAST = CW'(W_IN - 1);
  localparam logic [KW-1:0] K_LAST = KW'(CH - 1);

  if ((H_IN % 2) != 0 || (W_IN % 2) != 0) begin : g_bad_dims
    $fatal(1, "maxpool2d_stream: H_IN and W_IN must both be even");
  end
  if (DATA_W != cnn_stream_pkg::DATA_W) begin : g_bad_width
    $fatal(1, "maxpool2d_stream: DATA_W must match cnn_stream_pkg::DATA_W");
  end

  stream_state_t     r_state;
  logic [RW-1:0]     r_r;
  logic [CW-1:0]     r_c;
  logic [KW-1:0]     r_ch;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_last;
  logic              r_done;

  logic              w_in_hs;
  logic              w_out_hs;
  logic              w_last_in;
  logic              w_r_odd;
  logic              w_c_odd;
  logic              w_emit;
  logic              w_pb_we;
  logic [AW-1:0]     w_pb_addr;
  logic [DATA_W-1:0] w_pb_rdata;
  logic [DATA_W-1:0] w_pb_wdata;
  logic [DATA_W-1:0] w_max;

  assign in_ready  = (r_state == RUN) && (!r_out_valid || out_ready);
  assign w_in_hs   = in_valid && in_ready;
  assign w_out_hs  = r_out_valid && out_ready;
  assign w_last_in = (r_r == R_LAST) && (r_c == C_LAST) && (r_ch == K_LAST);
  assign w_r_odd   = r_r[0];
  assign w_c_odd   = r_c[0];
  assign w_emit    = w_in_hs && w_r_odd && w_c_odd;

  // Both columns of a pooling pair share one entry: index by (c/2, ch).
  assign w_pb_addr  = AW'(((32'(r_c) >> 1) * CH) + 32'(r_ch));
  assign w_max      = smax(w_pb_rdata, in_data);
  assign w_pb_we    = w_in_hs && !(w_r_odd && w_c_odd);
  assign w_pb_wdata = (!w_r_odd && !w_c_odd) ? in_data : w_max;

  pool_line_buf #(
    .DEPTH  (DEPTH),
    .ADDR_W (AW),
    .WORD_W (DATA_W)
  ) u_pbuf (
    .clk     (clk),
    .i_we    (w_pb_we),
    .i_addr  (w_pb_addr),
    .i_wdata (w_pb_wdata),
    .o_rdata (w_pb_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_r         <= '0;
      r_c         <= '0;
      r_ch        <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_r     <= '0;
            r_c     <= '0;
            r_ch    <= '0;
          end
        end
        RUN: begin
          if (w_in_hs) begin
            if (r_ch == K_LAST) begin
              r_ch <= '0;
              if (r_c == C_LAST) begin
                r_c <= '0;
                r_r <= (r_r == R_LAST) ? '0 : r_r + RW'(1);
              end else begin
                r_c <= r_c + CW'(1);
              end
            end else begin
              r_ch <= r_ch + KW'(1);
            end
            if (w_last_in) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_out_hs && r_out_last) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase

      // A new pooled word takes priority over clearing on handshake.
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_max;
        r_out_last  <= w_last_in;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_maxpool2d_stream.sv
// Randomized self-checking bench for maxpool2d_stream: three instances
// (4x4x1, 4x4x2, 32x32x28) checked against a direct 2x2 pooling model.
module tb_maxpool2d_stream;

  logic        clk;
  logic        rst_n;
  logic        st   [3];
  logic        vin  [3];
  logic [31:0] din  [3];
  logic        rdy  [3];
  logic        ir   [3];
  logic        ov   [3];
  logic [31:0] od   [3];
  logic        ol   [3];
  logic        bz   [3];
  logic        dn   [3];

  int n_checks;
  int n_errors;

  logic [31:0] stim  [$];
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];
  logic        gotl_q[$];

  maxpool2d_stream #(.H_IN(4), .W_IN(4), .CH(1), .DATA_W(32)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .in_valid(vin[0]), .in_ready(ir[0]),
    .in_data(din[0]), .out_valid(ov[0]), .out_ready(rdy[0]), .out_data(od[0]),
    .out_last(ol[0]), .busy(bz[0]), .done(dn[0]));

  maxpool2d_stream #(.H_IN(4), .W_IN(4), .CH(2), .DATA_W(32)) u_s2 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .in_valid(vin[1]), .in_ready(ir[1]),
    .in_data(din[1]), .out_valid(ov[1]), .out_ready(rdy[1]), .out_data(od[1]),
    .out_last(ol[1]), .busy(bz[1]), .done(dn[1]));

  maxpool2d_stream #(.H_IN(32), .W_IN(32), .CH(28), .DATA_W(32)) u_big (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .in_valid(vin[2]), .in_ready(ir[2]),
    .in_data(din[2]), .out_valid(ov[2]), .out_ready(rdy[2]), .out_data(od[2]),
    .out_last(ol[2]), .busy(bz[2]), .done(dn[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pooled map straight from the definition: max of each 2x2 window per channel.
  task automatic build_expected(input int h, input int w, input int c);
    logic signed [31:0] m;
    logic signed [31:0] v;
    exp_q.delete();
    for (int pr = 0; pr < h / 2; pr++)
      for (int pc = 0; pc < w / 2; pc++)
        for (int k = 0; k < c; k++) begin
          m = stim[((2 * pr) * w + 2 * pc) * c + k];
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
              v = stim[((2 * pr + dr) * w + 2 * pc + dc) * c + k];
              if (v > m) m = v;
            end
          exp_q.push_back(m);
        end
  endtask

  task automatic run_frame(input int sel, input int vin_pct, input int rdy_pct,
                           input bit poke, output int cycles);
    int          n;
    int          idx;
    int          budget;
    int          push_cyc;
    bit          done_seen;
    bit          stall;
    logic [31:0] held;
    logic        heldl;
    n = stim.size();
    idx = 0; cycles = 0; push_cyc = -10; done_seen = 0; stall = 0;
    held = '0; heldl = 1'b0;
    budget = 4 * n + 200;
    got_q.delete(); gotl_q.delete();

    @(negedge clk); st[sel] = 1'b1;
    @(negedge clk); st[sel] = 1'b0;
    n_checks++;
    if (bz[sel] !== 1'b1) begin
      n_errors++; $display("FAIL busy_after_start[%0d]: got %b expected 1", sel, bz[sel]);
    end

    while (!done_seen && cycles < budget) begin
      rdy[sel] = ($urandom_range(99) < rdy_pct);
      if (idx < n) begin
        vin[sel] = ($urandom_range(99) < vin_pct);
        din[sel] = stim[idx];
        if (poke) st[sel] = $urandom_range(1);
      end else begin
        vin[sel] = poke;
        din[sel] = $urandom;
        st[sel]  = 1'b0;
      end
      #1;
      if (idx >= n) begin
        n_checks++;
        if (ir[sel] !== 1'b0) begin
          n_errors++; $display("FAIL in_ready_drain[%0d]: got %b expected 0", sel, ir[sel]);
        end
      end
      if (vin[sel] && ir[sel] && idx < n) idx++;
      if (ov[sel] && rdy[sel]) begin
        got_q.push_back(od[sel]);
        gotl_q.push_back(ol[sel]);
        push_cyc = cycles;
      end
      stall = ov[sel] && !rdy[sel];
      held  = od[sel];
      heldl = ol[sel];
      @(negedge clk);
      cycles++;
      if (stall) begin
        n_checks++;
        if (ov[sel] !== 1'b1 || od[sel] !== held || ol[sel] !== heldl) begin
          n_errors++;
          $display("FAIL stall_hold[%0d]: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                   sel, ov[sel], od[sel], ol[sel], held, heldl);
        end
      end
      if (dn[sel] === 1'b1) done_seen = 1;
    end

    vin[sel] = 1'b0; st[sel] = 1'b0; rdy[sel] = 1'b1;
    n_checks++;
    if (!done_seen) begin
      n_errors++; $display("FAIL done_timeout[%0d]: got no done after %0d cycles expected done", sel, cycles);
    end else begin
      n_checks++;
      if (push_cyc + 1 != cycles) begin
        n_errors++;
        $display("FAIL done_timing[%0d]: got done at %0d expected %0d", sel, cycles, push_cyc + 1);
      end
    end

    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL out_count[%0d]: got %0d expected %0d", sel, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin
        n_errors++; $display("FAIL out_data[%0d] #%0d: got %h expected %h", sel, i, got_q[i], exp_q[i]);
      end
      n_checks++;
      if (gotl_q[i] !== (i == exp_q.size() - 1)) begin
        n_errors++; $display("FAIL out_last[%0d] #%0d: got %b expected %b", sel, i, gotl_q[i], (i == exp_q.size() - 1));
      end
    end

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (dn[sel] !== 1'b0 || bz[sel] !== 1'b0 || ov[sel] !== 1'b0) begin
        n_errors++;
        $display("FAIL post_done[%0d]: got done=%b busy=%b ov=%b expected 0 0 0", sel, dn[sel], bz[sel], ov[sel]);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      n_checks++;
      if ({ir[s], ov[s], ol[s], bz[s], dn[s]} !== 5'b0 || od[s] !== 32'h0) begin
        n_errors++;
        $display("FAIL reset_vals[%0d]: got ir=%b ov=%b od=%h ol=%b bz=%b dn=%b expected all 0",
                 s, ir[s], ov[s], od[s], ol[s], bz[s], dn[s]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_channel();
    int cyc;
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(32'(i));
    build_expected(4, 4, 1);
    run_frame(0, 100, 100, 1'b0, cyc);
    n_checks++;
    if (cyc != 17) begin
      n_errors++; $display("FAIL throughput_4x4x1: got %0d cycles expected 17", cyc);
    end
  endtask

  task automatic test_two_channel();
    int cyc;
    stim.delete();
    for (int i = 0; i < 16; i++) begin
      stim.push_back(32'(i));
      stim.push_back(32'(-i));
    end
    build_expected(4, 4, 2);
    run_frame(1, 100, 100, 1'b0, cyc);
    n_checks++;
    if (cyc != 33) begin
      n_errors++; $display("FAIL throughput_4x4x2: got %0d cycles expected 33", cyc);
    end
    run_frame(1, 60, 50, 1'b0, cyc);
  endtask

  task automatic test_random_full();
    int cyc;
    stim.delete();
    for (int i = 0; i < 32 * 32 * 28; i++) stim.push_back($urandom);
    build_expected(32, 32, 28);
    run_frame(2, 75, 50, 1'b0, cyc);
  endtask

  task automatic test_signed_extreme();
    int cyc;
    stim.delete();
    for (int i = 0; i < 32 * 32 * 28; i++) stim.push_back(32'h8000_0000);
    stim[(1 * 32 + 1) * 28 + 0] = 32'h7FFF_FFFF;
    build_expected(32, 32, 28);
    run_frame(2, 100, 100, 1'b0, cyc);
  endtask

  task automatic test_reset_midframe();
    int acc;
    int guard;
    int cyc;
    acc = 0; guard = 0;
    @(negedge clk); st[0] = 1'b1; st[2] = 1'b1;
    @(negedge clk); st[0] = 1'b0; st[2] = 1'b0;
    rdy[0] = 1'b1; rdy[2] = 1'b1;
    while (acc < 100 && guard < 1000) begin
      vin[2] = 1'b1; din[2] = $urandom;
      vin[0] = (acc < 10); din[0] = $urandom;
      #1;
      if (ir[2]) acc++;
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (acc != 100) begin
      n_errors++; $display("FAIL midframe_feed: got %0d words expected 100", acc);
    end
    vin[0] = 1'b0; vin[2] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int s = 0; s < 3; s += 2) begin
      n_checks++;
      if ({ir[s], ov[s], ol[s], bz[s], dn[s]} !== 5'b0 || od[s] !== 32'h0) begin
        n_errors++;
        $display("FAIL abort_vals[%0d]: got ir=%b ov=%b od=%h ol=%b bz=%b dn=%b expected all 0",
                 s, ir[s], ov[s], od[s], ol[s], bz[s], dn[s]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    vin[2] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ir[2] !== 1'b0 || bz[2] !== 1'b0) begin
      n_errors++; $display("FAIL restart_needs_start: got ir=%b busy=%b expected 0 0", ir[2], bz[2]);
    end
    vin[2] = 1'b0;
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(32'(i));
    build_expected(4, 4, 1);
    run_frame(0, 100, 100, 1'b0, cyc);
  endtask

  task automatic test_ignore_start_valid();
    int cyc;
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back($urandom);
    build_expected(4, 4, 1);
    run_frame(0, 80, 30, 1'b1, cyc);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      st[s] = 1'b0; vin[s] = 1'b0; din[s] = '0; rdy[s] = 1'b0;
    end
    test_reset();
    test_single_channel();
    test_two_channel();
    test_random_full();
    test_signed_extreme();
    test_reset_midframe();
    test_ignore_start_valid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/maxpool2d_stream.md
# maxpool2d_stream

Streaming 2x2, stride-2 max-pool stage that sits directly downstream of the 2D convolution stage. It consumes the conv output feature map one 32-bit word per handshake, in conv raster order: row, then column, then channel innermost. It emits the pooled map in the same order. A per-column partial-max line buffer lets the whole frame pass at one word per cycle with no frame-sized storage.

## Interface
- `H_IN`, 32: input rows; must be even.
- `W_IN`, 32: input columns; must be even.
- `CH`, 28: channels; equals the conv `CH_OUT`.
- `DATA_W`, 32: signed word width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: arms a frame; sampled only in IDLE.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: block accepts the input word.
- `in_data` in DATA_W: signed conv output word.
- `out_valid` out 1: pooled word valid.
- `out_ready` in 1: downstream accepts the pooled word.
- `out_data` out DATA_W: signed pooled word.
- `out_last` out 1: qualifies the final pooled word of the frame.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse at frame completion.

## Operation
- States:
  - IDLE: `start` -> RUN; clears row, column and channel counters.
  - RUN: accepts input words; on the input handshake of the final word (r=H_IN-1, c=W_IN-1, ch=CH-1) -> DRAIN.
  - DRAIN: waits for the output handshake of the last word, then -> IDLE and pulses `done`.
- Input handshake occurs when `in_valid && in_ready`.
- `in_ready` = (state==RUN) && (!out_valid || out_ready). This is combinational from `out_ready`, which gives full throughput.
- Counters advance per input handshake:
  - `ch` wraps at CH and increments `c`.
  - `c` wraps at W_IN and increments `r`.
- Line buffer `pbuf` has W_IN/2*CH signed entries, indexed (c>>1)*CH+ch. Action per input word x, by (r even?, c even?):
  - even/even: `pbuf` <= x.
  - even/odd: `pbuf` <= max(`pbuf`, x).
  - odd/even: `pbuf` <= max(`pbuf`, x).
  - odd/odd: no write; `out_data` <= max(`pbuf`, x) and `out_valid` <= 1.
- Max is a signed DATA_W compare. Ties are irrelevant to the result. No rescale, no saturation: `out_data` is always one of the input words.
- Output register `out_valid` clears on an output handshake unless a new odd/odd word loads in the same cycle, in which case it stays 1 with the new data.
- `out_last` = `out_valid` && the held word is pooled index (H_IN/2-1, W_IN/2-1, CH-1).
- Output word count per frame is (H_IN/2)*(W_IN/2)*CH, which is 7168 at the defaults.
- `start` is ignored in RUN and DRAIN. `in_valid` is ignored in IDLE and DRAIN.
- `pbuf` is not reset: the first access per entry on an even row is always an overwrite.
- Odd H_IN or W_IN is unsupported: elaboration-time check calls `$fatal`.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0; state IDLE; counters 0.
- `rst_n` low mid-frame aborts immediately. The held output word is dropped and the next frame needs `start` again.
- `start` in IDLE at edge t -> `busy`=1 and `in_ready` may rise from t+1.
- Latency: the odd/odd input accepted at edge t -> `out_valid`=1 from t+1.
- Backpressure: while `out_valid && !out_ready`, `in_ready`=0. `out_data` and `out_last` stay stable until the handshake.
- The final input handshake and the output handshake of an earlier word can coincide, which is legal.
- `done` is high for exactly the cycle after the final output handshake. `start` asserted in that same cycle (state IDLE) is accepted.
- With `in_valid` and `out_ready` held high, the frame takes H_IN*W_IN*CH input cycles + 1 cycle, then `done`.

## Structure
- Shared package `cnn_stream_pkg`: DATA_W, state encoding (IDLE/RUN/DRAIN), signed max function. The conv stream wrapper reuses the same package.
- One sub-module `pool_line_buf`: single-port W_IN/2*CH x DATA_W array, one read and one write per cycle, asynchronous read.
- Top holds the FSM, counters, compare and output register.

## Test plan
- H_IN=W_IN=4, CH=1, inputs 0..15 in raster order, no stalls -> outputs 5,7,13,15; `out_last` on 15; `done` one cycle after 15 is accepted.
- CH=2, same 4x4 map per channel, ch1 = -(ch0) -> outputs interleaved 5,0,7,-2,13,-8,15,-10.
- Random `out_ready` (50%) and random `in_valid` on defaults 32x32x28 -> 7168 outputs, bit-exact to a software pooling model, no `out_data` change while stalled.
- All inputs -2147483648 except a single 2147483647 at (1,1,0) -> output (0,0,0)=2147483647, all others -2147483648 (signed compare check).
- `rst_n` low after 100 input words -> all outputs at reset values; new `start` and full 4x4x1 frame -> correct 5,7,13,15.
- `start` pulsed during RUN and `in_valid` during DRAIN -> ignored, output count unchanged, single `done`.
